// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES definitions. Contains the 4x4 byte state type, the
//               key-schedule sizes, the round-constant table, and helpers for
//               column-major byte placement and round-constant lookup.
// Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_NK = 4;   // key length in 32-bit words
    localparam int AES_NR = 10;  // number of rounds

    // The state is indexed [column][row][bit]. Column 0 row 0 is the MSB byte,
    // so the packed value lines up with the flattened 128-bit key layout.
    typedef logic [0:3][0:3][7:0] aes_state_t;

    localparam logic [7:0] AES_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // MSB position of state byte [r][c] inside the flattened 128-bit vector.
    function automatic int aes_byte_msb(input int r, input int c);
        return 127 - 8 * (4 * c + r);
    endfunction

    // Round constant for rounds 1..10. Any other index yields zero, so an
    // out-of-range counter value can never read past the table.
    function automatic logic [7:0] aes_rcon(input logic [3:0] round);
        logic [7:0] v;
        v = 8'h00;
        if (round >= 4'd1 && round <= 4'd10) begin
            v = AES_RCON[round];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box (8-bit lookup).
//               i_byte : input byte
//               o_byte : substituted byte
// Revision    : 1.0  initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Row n of the literal holds entries 16n..16n+15; entry 0 is leftmost.
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[i_byte];

endmodule
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expander
// Description : Iterative AES-128 key schedule. A start request loads the
//               cipher key as round key 0. One expansion step per clock then
//               produces round keys 1..10, each with a valid strobe and index.
//   clk       : system clock, rising edge
//   reset     : asynchronous reset, active low
//   start     : single-cycle request; key_in is sampled when accepted
//   key_in    : 128-bit cipher key, column-major (w0 = [127:96])
//   busy      : expansion in progress; start is ignored while high
//   rk_valid  : round_key / rk_idx are valid this cycle
//   rk_idx    : round index 0..10
//   round_key : round key, same byte layout as key_in
//   done      : one-cycle pulse together with round key 10
// Revision    : 1.0  initial release
// ============================================================================
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR  // only 10 (AES-128) is supported
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic [127:0] round_key,
    output logic         done
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_EXPAND = 1'b1;
    localparam logic [3:0] c_LAST      = 4'(NUM_ROUNDS);

    logic [0:0]   r_state;
    logic         r_busy;
    logic         r_rk_valid;
    logic         r_done;
    logic [3:0]   r_idx;
    logic [127:0] r_round_key;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [7:0]   w_rcon;
    logic [31:0]  w_n0, w_n1, w_n2, w_n3;
    logic [3:0]   w_idx_next;

    // The previous round key is the only history the schedule needs.
    assign w_w0 = r_round_key[127:96];
    assign w_w1 = r_round_key[95:64];
    assign w_w2 = r_round_key[63:32];
    assign w_w3 = r_round_key[31:0];

    // RotWord moves the MSB byte to the LSB position.
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar g = 0; g < AES_NK; g++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (w_rot[8*g +: 8]),
                .o_byte (w_sub[8*g +: 8])
            );
        end
    endgenerate

    assign w_idx_next = r_idx + 4'd1;
    assign w_rcon     = aes_rcon(w_idx_next);
    assign w_temp     = w_sub ^ {w_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_busy      <= 1'b0;
            r_rk_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_idx       <= 4'd0;
            r_round_key <= 128'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done     <= 1'b0;
                    r_rk_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    if (start) begin
                        r_round_key <= key_in;
                        r_idx       <= 4'd0;
                        r_rk_valid  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= c_ST_EXPAND;
                    end
                end
                c_ST_EXPAND: begin
                    if (r_idx == c_LAST) begin
                        // Last key has been presented; round_key and rk_idx
                        // keep their values for the consumer.
                        r_state    <= c_ST_IDLE;
                        r_busy     <= 1'b0;
                        r_rk_valid <= 1'b0;
                        r_done     <= 1'b0;
                    end else begin
                        r_round_key <= {w_n0, w_n1, w_n2, w_n3};
                        r_idx       <= w_idx_next;
                        r_rk_valid  <= 1'b1;
                        r_done      <= (w_idx_next == c_LAST);
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_busy     <= 1'b0;
                    r_rk_valid <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign rk_valid  = r_rk_valid;
    assign rk_idx    = r_idx;
    assign round_key = r_round_key;
    assign done      = r_done;

endmodule
`default_nettype wire
